// File: rtl/cronometro_bcd.sv
`default_nettype none
// ============================================================================
// Module   : cronometro_bcd
// Brief    : MM:SS BCD stopwatch driven by a 1 Hz tick, with start/pause and
//            clear buttons. Define CONTAGEM_REGRESSIVA_EN for load + countdown.
// Revision : 1.0 - initial release
// ============================================================================
module cronometro_bcd #(
  parameter int MINUTO_MAX    = 59,
  parameter int SINC_ESTAGIOS = 2
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        umSegundo,
  input  logic        iniciarPausar,
  input  logic        zerar,
`ifdef CONTAGEM_REGRESSIVA_EN
  input  logic        modoRegressivo,
  input  logic        carregar,
  input  logic [15:0] valorCarga,
  output logic        fimContagem,
`endif
  output logic [3:0]  unidadeSegundos,
  output logic [3:0]  dezenaSegundos,
  output logic [3:0]  unidadeMinuto,
  output logic [3:0]  dezenaMinuto,
  output logic        rodando,
  output logic        estouro
);

  localparam logic [3:0] c_maxDez = 4'(MINUTO_MAX / 10);
  localparam logic [3:0] c_maxUni = 4'(MINUTO_MAX % 10);

`ifdef CONTAGEM_REGRESSIVA_EN
  typedef enum logic [1:0] {PARADO = 2'd0, CONTANDO = 2'd1, FIM = 2'd2} estado_t;
`else
  typedef enum logic [0:0] {PARADO = 1'b0, CONTANDO = 1'b1} estado_t;
`endif

  estado_t                  r_estado;
  logic [SINC_ESTAGIOS-1:0] r_syncIni;
  logic [SINC_ESTAGIOS-1:0] r_syncZer;
  logic                     r_antIni;
  logic                     r_antZer;
  logic                     w_bordaIni;
  logic                     w_bordaZer;
  logic [3:0]               r_uS, r_dS, r_uM, r_dM;
  logic                     r_estouro;
  logic [3:0]               w_upUS, w_upDS, w_upUM, w_upDM;
  logic                     w_minMax;
  logic                     w_upWrap;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_syncIni <= '0;
      r_syncZer <= '0;
      r_antIni  <= 1'b0;
      r_antZer  <= 1'b0;
    end else begin
      r_syncIni[0] <= iniciarPausar;
      r_syncZer[0] <= zerar;
      for (int i = 1; i < SINC_ESTAGIOS; i++) begin
        r_syncIni[i] <= r_syncIni[i-1];
        r_syncZer[i] <= r_syncZer[i-1];
      end
      r_antIni <= r_syncIni[SINC_ESTAGIOS-1];
      r_antZer <= r_syncZer[SINC_ESTAGIOS-1];
    end
  end

  assign w_bordaIni = r_syncIni[SINC_ESTAGIOS-1] & ~r_antIni;
  assign w_bordaZer = r_syncZer[SINC_ESTAGIOS-1] & ~r_antZer;

  assign w_minMax = (r_dM == c_maxDez) && (r_uM == c_maxUni);
  assign w_upWrap = w_minMax && (r_dS == 4'd5) && (r_uS == 4'd9);

  always_comb begin
    w_upUS = r_uS + 4'd1;
    w_upDS = r_dS;
    w_upUM = r_uM;
    w_upDM = r_dM;
    if (r_uS == 4'd9) begin
      w_upUS = 4'd0;
      w_upDS = r_dS + 4'd1;
      if (r_dS == 4'd5) begin
        w_upDS = 4'd0;
        if (w_minMax) begin
          w_upUM = 4'd0;
          w_upDM = 4'd0;
        end else if (r_uM == 4'd9) begin
          w_upUM = 4'd0;
          w_upDM = r_dM + 4'd1;
        end else begin
          w_upUM = r_uM + 4'd1;
        end
      end
    end
  end

`ifdef CONTAGEM_REGRESSIVA_EN
  logic [3:0] w_dnUS, w_dnDS, w_dnUM, w_dnDM;
  logic [3:0] w_cUS, w_cDS, w_cUM, w_cDM;
  logic [6:0] w_cMin;
  logic       w_cMinOk;
  logic       w_zero;
  logic       w_dnFim;
  logic       w_vaiFim;
  logic       r_fim;

  always_comb begin
    w_dnUS = r_uS - 4'd1;
    w_dnDS = r_dS;
    w_dnUM = r_uM;
    w_dnDM = r_dM;
    if (r_uS == 4'd0) begin
      w_dnUS = 4'd9;
      w_dnDS = r_dS - 4'd1;
      if (r_dS == 4'd0) begin
        w_dnDS = 4'd5;
        if (r_uM == 4'd0) begin
          w_dnUM = 4'd9;
          w_dnDM = r_dM - 4'd1;
        end else begin
          w_dnUM = r_uM - 4'd1;
        end
      end
    end
  end

  assign w_zero  = ({r_dM, r_uM, r_dS, r_uS} == 16'h0000);
  // Reaching (or already sitting at) 00:00 while counting down ends the run.
  assign w_dnFim = (r_dM == 4'd0) && (r_uM == 4'd0) && (r_dS == 4'd0) && (r_uS <= 4'd1);
  assign w_vaiFim = (r_estado == CONTANDO) && umSegundo && modoRegressivo && w_dnFim;

  assign w_cUS    = (valorCarga[3:0]   > 4'd9) ? 4'd0 : valorCarga[3:0];
  assign w_cDS    = (valorCarga[7:4]   > 4'd5) ? 4'd0 : valorCarga[7:4];
  assign w_cUM    = (valorCarga[11:8]  > 4'd9) ? 4'd0 : valorCarga[11:8];
  assign w_cDM    = (valorCarga[15:12] > 4'd9) ? 4'd0 : valorCarga[15:12];
  assign w_cMin   = {3'd0, w_cDM} * 7'd10 + {3'd0, w_cUM};
  assign w_cMinOk = (w_cMin <= 7'(MINUTO_MAX));
  assign fimContagem = r_fim;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_estado  <= PARADO;
      r_uS      <= 4'd0;
      r_dS      <= 4'd0;
      r_uM      <= 4'd0;
      r_dM      <= 4'd0;
      r_estouro <= 1'b0;
`ifdef CONTAGEM_REGRESSIVA_EN
      r_fim     <= 1'b0;
`endif
    end else begin
      r_estouro <= 1'b0;
`ifdef CONTAGEM_REGRESSIVA_EN
      r_fim     <= 1'b0;
`endif
      if (w_bordaZer) begin
        r_uS     <= 4'd0;
        r_dS     <= 4'd0;
        r_uM     <= 4'd0;
        r_dM     <= 4'd0;
        r_estado <= PARADO;
      end else begin
        case (r_estado)
          CONTANDO: begin
            if (umSegundo) begin
`ifdef CONTAGEM_REGRESSIVA_EN
              if (modoRegressivo) begin
                if (w_dnFim) begin
                  {r_dM, r_uM, r_dS, r_uS} <= 16'h0000;
                  r_estado <= FIM;
                  r_fim    <= 1'b1;
                end else begin
                  {r_dM, r_uM, r_dS, r_uS} <= {w_dnDM, w_dnUM, w_dnDS, w_dnUS};
                end
              end else begin
                {r_dM, r_uM, r_dS, r_uS} <= {w_upDM, w_upUM, w_upDS, w_upUS};
                r_estouro <= w_upWrap;
              end
`else
              {r_dM, r_uM, r_dS, r_uS} <= {w_upDM, w_upUM, w_upDS, w_upUS};
              r_estouro <= w_upWrap;
`endif
            end
`ifdef CONTAGEM_REGRESSIVA_EN
            if (w_bordaIni && !w_vaiFim) r_estado <= PARADO;
`else
            if (w_bordaIni) r_estado <= PARADO;
`endif
          end
          PARADO: begin
`ifdef CONTAGEM_REGRESSIVA_EN
            if (carregar) begin
              {r_dM, r_uM} <= w_cMinOk ? {w_cDM, w_cUM} : 8'h00;
              {r_dS, r_uS} <= {w_cDS, w_cUS};
            end else if (w_bordaIni) begin
              if (modoRegressivo && w_zero) begin
                r_estado <= FIM;
                r_fim    <= 1'b1;
              end else begin
                r_estado <= CONTANDO;
              end
            end
`else
            if (w_bordaIni) r_estado <= CONTANDO;
`endif
          end
`ifdef CONTAGEM_REGRESSIVA_EN
          FIM: begin
            if (carregar) begin
              {r_dM, r_uM} <= w_cMinOk ? {w_cDM, w_cUM} : 8'h00;
              {r_dS, r_uS} <= {w_cDS, w_cUS};
              r_estado     <= PARADO;
            end
          end
`endif
          default: r_estado <= PARADO;
        endcase
      end
    end
  end

  assign unidadeSegundos = r_uS;
  assign dezenaSegundos  = r_dS;
  assign unidadeMinuto   = r_uM;
  assign dezenaMinuto    = r_dM;
  assign rodando         = (r_estado == CONTANDO);
  assign estouro         = r_estouro;

endmodule
`default_nettype wire

// File: tb/tb_cronometro_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_cronometro_bcd
// Brief    : Randomized self-checking bench for cronometro_bcd against a
//            seconds-count reference model (MINUTO_MAX 59 and 1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cronometro_bcd;

  localparam int SINC = 2;
  localparam int MAXA = 59;
  localparam int MAXB = 1;
  localparam int PERA = (MAXA + 1) * 60;
  localparam int PERB = (MAXB + 1) * 60;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic umSegundo = 1'b0;
  logic iniciarPausar = 1'b0;
  logic zerar = 1'b0;
  logic [3:0] uSA, dSA, uMA, dMA, uSB, dSB, uMB, dMB;
  logic rodA, estA, rodB, estB;
`ifdef CONTAGEM_REGRESSIVA_EN
  logic modoRegressivo = 1'b0;
  logic carregar = 1'b0;
  logic [15:0] valorCarga = 16'h0000;
  logic fimA, fimB;
  int cntFimA = 0, cntFimB = 0;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  cronometro_bcd #(.MINUTO_MAX(MAXA), .SINC_ESTAGIOS(SINC)) dutA (
    .clock(clock), .resetN(resetN), .umSegundo(umSegundo),
    .iniciarPausar(iniciarPausar), .zerar(zerar),
`ifdef CONTAGEM_REGRESSIVA_EN
    .modoRegressivo(modoRegressivo), .carregar(carregar),
    .valorCarga(valorCarga), .fimContagem(fimA),
`endif
    .unidadeSegundos(uSA), .dezenaSegundos(dSA), .unidadeMinuto(uMA),
    .dezenaMinuto(dMA), .rodando(rodA), .estouro(estA)
  );

  cronometro_bcd #(.MINUTO_MAX(MAXB), .SINC_ESTAGIOS(SINC)) dutB (
    .clock(clock), .resetN(resetN), .umSegundo(umSegundo),
    .iniciarPausar(iniciarPausar), .zerar(zerar),
`ifdef CONTAGEM_REGRESSIVA_EN
    .modoRegressivo(modoRegressivo), .carregar(carregar),
    .valorCarga(valorCarga), .fimContagem(fimB),
`endif
    .unidadeSegundos(uSB), .dezenaSegundos(dSB), .unidadeMinuto(uMB),
    .dezenaMinuto(dMB), .rodando(rodB), .estouro(estB)
  );

  wire [15:0] digA = {dMA, uMA, dSA, uSA};
  wire [15:0] digB = {dMB, uMB, dSB, uSB};

  // Reference model: elapsed seconds modulo the period, run flag, button
  // events seen SINC posedges after the first posedge sampling the level high.
  int secA = 0, secB = 0, wrapsB = 0, cntEstA = 0, cntEstB = 0;
  bit runM = 0, estBm = 0;
  logic [SINC+1:0] hIni = '0, hZer = '0;

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      secA = 0; secB = 0; runM = 0; estBm = 0; hIni = '0; hZer = '0;
    end else begin
      hIni = {hIni[SINC:0], iniciarPausar};
      hZer = {hZer[SINC:0], zerar};
      estBm = 0;
      if (hZer[SINC] && !hZer[SINC+1]) begin
        secA = 0; secB = 0; runM = 0;
      end else begin
        if (runM && umSegundo) begin
          secA = (secA + 1) % PERA;
          secB = secB + 1;
          if (secB == PERB) begin secB = 0; estBm = 1; wrapsB++; end
        end
        if (hIni[SINC] && !hIni[SINC+1]) runM = !runM;
      end
    end
  end

  always @(posedge clock) begin
    if (estA) cntEstA++;
    if (estB) cntEstB++;
`ifdef CONTAGEM_REGRESSIVA_EN
    if (fimA) cntFimA++;
    if (fimB) cntFimB++;
`endif
  end

  function automatic logic [15:0] bcd(int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tick();
    umSegundo = 1'b1;
    cyc(1);
    umSegundo = 1'b0;
    cyc($urandom_range(0, 2));
  endtask

  task automatic pressIni();
    iniciarPausar = 1'b1;
    cyc($urandom_range(1, 3));
    iniciarPausar = 1'b0;
    cyc(SINC + 2);
  endtask

  task automatic pressZer();
    zerar = 1'b1;
    cyc($urandom_range(1, 3));
    zerar = 1'b0;
    cyc(SINC + 2);
  endtask

  task automatic doReset();
    resetN = 1'b0;
    cyc(2);
    resetN = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if (digA !== 16'h0000 || rodA !== 1'b0 || estA !== 1'b0)
      $display("FAIL reset_state: got %h rod=%b est=%b, want 0000 0 0", digA, rodA, estA);
    else passed++;
    pressIni();
    repeat (7) tick();
    total++;
    if (digA !== 16'h0007 || rodA !== 1'b1)
      $display("FAIL seven_ticks: got %h rod=%b, want 0007 1", digA, rodA);
    else passed++;
    #2 resetN = 1'b0;
    #1;
    total++;
    if (digA !== 16'h0000 || rodA !== 1'b0)
      $display("FAIL async_reset: got %h rod=%b, want 0000 0", digA, rodA);
    else passed++;
    cyc(1);
    resetN = 1'b1;
    cyc(2);
  endtask

  task automatic test_contagem();
    doReset();
    pressIni();
    repeat (599) tick();
    total++;
    if (digA !== 16'h0959) $display("FAIL count_0959: got %h, want 0959", digA);
    else passed++;
    total++;
    if (digB !== bcd(secB)) $display("FAIL count_b_model: got %h, want %h", digB, bcd(secB));
    else passed++;
    tick();
    cyc(2);
    total++;
    if (digA !== 16'h1000) $display("FAIL count_1000: got %h, want 1000", digA);
    else passed++;
    total++;
    if (cntEstA !== 0) $display("FAIL no_overflow_a: got %0d pulses, want 0", cntEstA);
    else passed++;
    total++;
    if (cntEstB !== wrapsB) $display("FAIL overflow_b_count: got %0d, want %0d", cntEstB, wrapsB);
    else passed++;
  endtask

  task automatic test_estouro();
    doReset();
    pressIni();
    repeat (119) tick();
    total++;
    if (digB !== 16'h0159) $display("FAIL wrap_pre: got %h, want 0159", digB);
    else passed++;
    umSegundo = 1'b1;
    cyc(1);
    umSegundo = 1'b0;
    total++;
    if (digB !== 16'h0000 || estB !== 1'b1)
      $display("FAIL wrap_edge: got %h est=%b, want 0000 1", digB, estB);
    else passed++;
    total++;
    if (digA !== 16'h0200 || estA !== 1'b0)
      $display("FAIL wrap_a_side: got %h est=%b, want 0200 0", digA, estA);
    else passed++;
    cyc(1);
    total++;
    if (estB !== 1'b0) $display("FAIL wrap_pulse_len: got est=%b, want 0", estB);
    else passed++;
  endtask

  task automatic test_pausa();
    doReset();
    pressIni();
    repeat (5) tick();
    pressIni();
    repeat (4) tick();
    total++;
    if (digA !== 16'h0005 || rodA !== 1'b0)
      $display("FAIL paused: got %h rod=%b, want 0005 0", digA, rodA);
    else passed++;
    pressIni();
    repeat (3) tick();
    total++;
    if (digA !== 16'h0008) $display("FAIL resumed: got %h, want 0008", digA);
    else passed++;
    iniciarPausar = 1'b1;
    cyc(SINC);
    umSegundo = 1'b1;
    cyc(1);
    umSegundo = 1'b0;
    cyc(1);
    total++;
    if (digA !== 16'h0009 || rodA !== 1'b0)
      $display("FAIL pause_with_tick: got %h rod=%b, want 0009 0", digA, rodA);
    else passed++;
    repeat (3) tick();
    iniciarPausar = 1'b0;
    cyc(SINC + 2);
    total++;
    if (digA !== 16'h0009) $display("FAIL held_pause: got %h, want 0009", digA);
    else passed++;
  endtask

  task automatic test_zerar();
    doReset();
    pressIni();
    repeat (42) tick();
    total++;
    if (digA !== 16'h0042) $display("FAIL reach_0042: got %h, want 0042", digA);
    else passed++;
    iniciarPausar = 1'b1;
    zerar = 1'b1;
    cyc(SINC + 1);
    total++;
    if (digA !== 16'h0000 || rodA !== 1'b0)
      $display("FAIL clear_priority: got %h rod=%b, want 0000 0", digA, rodA);
    else passed++;
    repeat (6) tick();
    total++;
    if (digA !== 16'h0000 || rodA !== 1'b0)
      $display("FAIL held_buttons: got %h rod=%b, want 0000 0", digA, rodA);
    else passed++;
    iniciarPausar = 1'b0;
    zerar = 1'b0;
    cyc(SINC + 2);
  endtask

  task automatic test_aleatorio();
    doReset();
    for (int i = 0; i < 700; i++) begin
      cyc(1);
      total++;
      if (digA !== bcd(secA)) $display("FAIL rand_digits_a@%0d: got %h, want %h", i, digA, bcd(secA));
      else passed++;
      total++;
      if (digB !== bcd(secB) || estB !== estBm)
        $display("FAIL rand_b@%0d: got %h est=%b, want %h est=%b", i, digB, estB, bcd(secB), estBm);
      else passed++;
      total++;
      if (rodA !== runM || rodB !== runM)
        $display("FAIL rand_rodando@%0d: got %b/%b, want %b", i, rodA, rodB, runM);
      else passed++;
      umSegundo = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 19) == 0) iniciarPausar = ~iniciarPausar;
      if (zerar) zerar = ($urandom_range(0, 2) != 0);
      else zerar = ($urandom_range(0, 99) == 0);
    end
    umSegundo = 1'b0;
    iniciarPausar = 1'b0;
    zerar = 1'b0;
    cyc(SINC + 2);
  endtask

`ifdef CONTAGEM_REGRESSIVA_EN
  task automatic test_regressiva();
    int baseA, baseB;
    doReset();
    modoRegressivo = 1'b1;
    valorCarga = 16'h0100;
    carregar = 1'b1;
    cyc(1);
    carregar = 1'b0;
    total++;
    if (digA !== 16'h0100 || digB !== 16'h0100)
      $display("FAIL load_0100: got %h/%h, want 0100", digA, digB);
    else passed++;
    baseA = cntFimA;
    baseB = cntFimB;
    pressIni();
    repeat (60) tick();
    cyc(2);
    total++;
    if (digA !== 16'h0000 || rodA !== 1'b0 || cntFimA - baseA !== 1 || cntFimB - baseB !== 1)
      $display("FAIL down_end: got %h rod=%b pulses=%0d/%0d, want 0000 0 1/1",
               digA, rodA, cntFimA - baseA, cntFimB - baseB);
    else passed++;
    repeat (5) tick();
    pressIni();
    total++;
    if (digA !== 16'h0000 || rodA !== 1'b0 || cntFimA - baseA !== 1)
      $display("FAIL fim_sticky: got %h rod=%b pulses=%0d, want 0000 0 1", digA, rodA, cntFimA - baseA);
    else passed++;
    valorCarga = 16'h0A75;
    carregar = 1'b1;
    cyc(1);
    carregar = 1'b0;
    total++;
    if (digA !== 16'h0005 || digB !== 16'h0005)
      $display("FAIL load_sanitize: got %h/%h, want 0005", digA, digB);
    else passed++;
    pressZer();
    pressIni();
    cyc(1);
    total++;
    if (digA !== 16'h0000 || rodA !== 1'b0 || cntFimA - baseA !== 2)
      $display("FAIL start_at_zero: got %h rod=%b pulses=%0d, want 0000 0 2", digA, rodA, cntFimA - baseA);
    else passed++;
    modoRegressivo = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_contagem();
    test_estouro();
    test_pausa();
    test_zerar();
    test_aleatorio();
`ifdef CONTAGEM_REGRESSIVA_EN
    test_regressiva();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
